request_dispatcher: RTL and testbench

- Downstream consumer of the frontend request FIFO.
- Pops one command at a time from the FIFO head, which is show-ahead: data is valid whenever empty=0.
- Routes each command to its target bank controller over a per-bank valid/ready handshake.
- Enforces a per-bank outstanding-command credit limit and tags each issued command with a row-hit hint from an open-row table.

---
 rtl/request_dispatcher.sv | 170 +++++++++++++++++
 tb/tb_request_dispatcher.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_dispatcher.sv
// request_dispatcher
//   Pops commands one at a time from a show-ahead request FIFO into a single
//   hold register. It presents each one to its target bank controller over a
//   per-bank valid/ready handshake. Each bank may have at most MAX_OUTSTANDING
//   unacknowledged commands. Every issued command carries a row-hit hint that
//   comes from a per-bank open-row table.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_fifo_data      FIFO head word {bank, row, col, op[1:0]}
//   i_fifo_empty     FIFO empty flag (head valid whenever low)
//   o_fifo_rd_en     combinational pop strobe
//   o_bank_valid     one-hot command valid, indexed by bank
//   o_bank_cmd       held command word, shared by all banks
//   o_row_hit        open-row hit hint for the held command
//   i_bank_ready     per-bank accept
//   i_bank_done      per-bank completion pulse, returns one credit
//   i_bank_closed    per-bank precharge pulse, invalidates the open row
//   o_busy           command held or any bank has outstanding work
//   o_err            sticky error (illegal op or credit underflow)
module request_dispatcher #(
  parameter int BANK_ADDR_BITS  = 3,
  parameter int ROW_ADDR_BITS   = 14,
  parameter int COL_ADDR_BITS   = 10,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CMD_W           = BANK_ADDR_BITS + ROW_ADDR_BITS + COL_ADDR_BITS + 2,
  localparam int NUM_BANKS      = 1 << BANK_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [CMD_W-1:0]     i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  output logic [NUM_BANKS-1:0] o_bank_valid,
  output logic [CMD_W-1:0]     o_bank_cmd,
  output logic                 o_row_hit,
  input  logic [NUM_BANKS-1:0] i_bank_ready,
  input  logic [NUM_BANKS-1:0] i_bank_done,
  input  logic [NUM_BANKS-1:0] i_bank_closed,
  output logic                 o_busy,
  output logic                 o_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {S_EMPTY, S_HOLD} state_e;

  state_e                   state_q, state_d;
  logic [CMD_W-1:0]         hold_q, hold_d;
  logic [CNT_W-1:0]         cnt_q [NUM_BANKS];
  logic [CNT_W-1:0]         cnt_d [NUM_BANKS];
  logic [ROW_ADDR_BITS-1:0] row_q [NUM_BANKS];
  logic [ROW_ADDR_BITS-1:0] row_d [NUM_BANKS];
  logic [NUM_BANKS-1:0]     row_v_q, row_v_d;
  logic                     err_q, err_d;

  logic                      hold_v;
  logic [BANK_ADDR_BITS-1:0] hold_bank;
  logic [ROW_ADDR_BITS-1:0]  hold_row;
  logic [1:0]                hold_op;
  logic                      legal_op;
  logic                      has_credit;
  logic                      issue;
  logic [NUM_BANKS-1:0]      fire_vec;
  logic                      fire;
  logic                      drop;
  logic                      can_load;
  logic                      busy_any;

  assign hold_v    = (state_q == S_HOLD);
  assign hold_bank = hold_q[CMD_W-1 -: BANK_ADDR_BITS];
  assign hold_row  = hold_q[COL_ADDR_BITS+2 +: ROW_ADDR_BITS];
  assign hold_op   = hold_q[1:0];

  // Ops 2'b10/2'b11 are illegal. They are never presented and are dropped
  // after one cycle in the hold register.
  assign legal_op   = ~hold_op[1];
  assign has_credit = (cnt_q[hold_bank] < MAX_CNT);
  assign issue      = hold_v & legal_op & has_credit;
  assign drop       = hold_v & ~legal_op;

  assign o_bank_valid = issue ? (NUM_BANKS'(1) << hold_bank) : '0;
  assign fire_vec     = o_bank_valid & i_bank_ready;
  assign fire         = |fire_vec;

  // The hold register is free when it is empty, or when it is being emptied
  // this cycle by a fire or an illegal-op drop.
  assign can_load = ~i_fifo_empty & (~hold_v | fire | drop);

  // Gated by reset so that no pop is signalled while the block is held in
  // reset.
  assign o_fifo_rd_en = can_load & i_rst_n;

  assign o_bank_cmd = hold_q;
  assign o_row_hit  = hold_v & row_v_q[hold_bank] & (row_q[hold_bank] == hold_row);
  assign o_busy     = hold_v | busy_any;
  assign o_err      = err_q;

  // Next-state logic for the hold register, the credit counters, the
  // open-row table and the error flag.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    row_v_d  = row_v_q;
    err_d    = err_q;
    busy_any = 1'b0;

    if (fire || drop) begin
      state_d = S_EMPTY;
    end
    if (can_load) begin
      state_d = S_HOLD;
      hold_d  = i_fifo_data;
    end
    if (drop) begin
      err_d = 1'b1;
    end

    for (int k = 0; k < NUM_BANKS; k++) begin
      if (cnt_q[k] != '0) begin
        busy_any = 1'b1;
      end

      // A fire and a done on the same bank in one cycle cancel out.
      // A done with no outstanding command is ignored and flagged.
      if (fire_vec[k] && !i_bank_done[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else if (!fire_vec[k] && i_bank_done[k]) begin
        if (cnt_q[k] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] - CNT_W'(1);
        end
      end

      // A fire opens the row and takes priority over a precharge in the
      // same cycle.
      if (fire_vec[k]) begin
        row_d[k]   = hold_row;
        row_v_d[k] = 1'b1;
      end else if (i_bank_closed[k]) begin
        row_v_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_EMPTY;
      hold_q  <= '0;
      row_v_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_BANKS; k++) begin
        cnt_q[k] <= '0;
        row_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      row_v_q <= row_v_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_request_dispatcher.sv
// tb_request_dispatcher
//   Self-checking bench for request_dispatcher with default parameters.
//   Inputs change on the falling edge. Outputs are sampled 1 ns later,
//   well away from the rising edge.
module tb_request_dispatcher;

  localparam int CMD_W = 29;
  localparam int NB    = 8;

  logic             clk;
  logic             rst_n;
  logic [CMD_W-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [NB-1:0]    bank_valid;
  logic [CMD_W-1:0] bank_cmd;
  logic             row_hit;
  logic [NB-1:0]    bank_ready;
  logic [NB-1:0]    bank_done;
  logic [NB-1:0]    bank_closed;
  logic             busy;
  logic             err;

  int n_cmp;
  int n_fail;

  request_dispatcher dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_fifo_data  (fifo_data),
    .i_fifo_empty (fifo_empty),
    .o_fifo_rd_en (fifo_rd_en),
    .o_bank_valid (bank_valid),
    .o_bank_cmd   (bank_cmd),
    .o_row_hit    (row_hit),
    .i_bank_ready (bank_ready),
    .i_bank_done  (bank_done),
    .i_bank_closed(bank_closed),
    .o_busy       (busy),
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             empty;
    logic [CMD_W-1:0] data;
    logic [NB-1:0]    ready;
    logic [NB-1:0]    done;
    logic [NB-1:0]    closed;
    logic             exp_rd;
    logic [NB-1:0]    exp_valid;
    logic [CMD_W-1:0] exp_cmd;
    logic             exp_hit;
    logic             exp_busy;
    logic             exp_err;
  } vec_t;

  function automatic logic [CMD_W-1:0] mk(int bank, int row, int col, int op);
    logic [2:0]  b;
    logic [13:0] r;
    logic [9:0]  c;
    logic [1:0]  o;
    b = bank[2:0];
    r = row[13:0];
    c = col[9:0];
    o = op[1:0];
    return {b, r, c, o};
  endfunction

  function automatic vec_t mkv(logic e, logic [CMD_W-1:0] d, logic [NB-1:0] rdy,
                               logic [NB-1:0] dn, logic [NB-1:0] cl, logic xr,
                               logic [NB-1:0] xv, logic [CMD_W-1:0] xc, logic xh,
                               logic xb, logic xe);
    vec_t v;
    v.empty = e;  v.data = d;  v.ready = rdy;  v.done = dn;  v.closed = cl;
    v.exp_rd = xr;  v.exp_valid = xv;  v.exp_cmd = xc;
    v.exp_hit = xh;  v.exp_busy = xb;  v.exp_err = xe;
    return v;
  endfunction

  // Compare a single value and report a mismatch.
  task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait for the falling edge, drive all inputs, then let them settle.
  task automatic applyStimulus(logic e, logic [CMD_W-1:0] d, logic [NB-1:0] rdy,
                               logic [NB-1:0] dn, logic [NB-1:0] cl);
    @(negedge clk);
    fifo_empty  = e;
    fifo_data   = d;
    bank_ready  = rdy;
    bank_done   = dn;
    bank_closed = cl;
    #1;
  endtask

  // Compare every output. The command word is only meaningful while valid.
  task automatic checkOutput(string name, logic xr, logic [NB-1:0] xv,
                             logic [CMD_W-1:0] xc, logic xh, logic xb, logic xe);
    compare({name, ".rd_en"}, 32'(fifo_rd_en), 32'(xr));
    compare({name, ".valid"}, 32'(bank_valid), 32'(xv));
    if (xv != '0) compare({name, ".cmd"}, 32'(bank_cmd), 32'(xc));
    compare({name, ".hit"},  32'(row_hit), 32'(xh));
    compare({name, ".busy"}, 32'(busy),    32'(xb));
    compare({name, ".err"},  32'(err),     32'(xe));
  endtask

  task automatic doReset();
    @(negedge clk);
    fifo_empty = 1'b1;  fifo_data = '0;  bank_ready = '1;
    bank_done = '0;  bank_closed = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t             vecs[13];
  logic [CMD_W-1:0] a, b1, b2, b3, c, d, e, f, h;
  logic [CMD_W-1:0] w[6];
  logic [CMD_W-1:0] g[4];
  int               idx;
  int               fires;
  int               mc;
  int               fv;
  int               dv;

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    fifo_empty = 1'b1;  fifo_data = '0;  bank_ready = '1;
    bank_done = '0;  bank_closed = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare("reset.cmd", 32'(bank_cmd), 32'h0);

    // Single read to bank 2, then back-to-back reads to bank 5 with a
    // precharge in between. Also covers fire and done on the same bank.
    a  = mk(2, 'h15, 3, 0);
    b1 = mk(5, 'h10, 1, 0);
    b2 = mk(5, 'h10, 2, 0);
    b3 = mk(5, 'h10, 3, 1);
    vecs[0]  = mkv(1, '0, '1, '0,    '0,    0, 8'h00, '0, 0, 0, 0);
    vecs[1]  = mkv(0, a,  '1, '0,    '0,    1, 8'h00, '0, 0, 0, 0);
    vecs[2]  = mkv(1, '0, '1, '0,    '0,    0, 8'h04, a,  0, 1, 0);
    vecs[3]  = mkv(1, '0, '1, 8'h04, '0,    0, 8'h00, '0, 0, 1, 0);
    vecs[4]  = mkv(1, '0, '1, '0,    '0,    0, 8'h00, '0, 0, 0, 0);
    vecs[5]  = mkv(0, b1, '1, '0,    '0,    1, 8'h00, '0, 0, 0, 0);
    vecs[6]  = mkv(0, b2, '1, '0,    '0,    1, 8'h20, b1, 0, 1, 0);
    vecs[7]  = mkv(1, '0, '1, '0,    '0,    0, 8'h20, b2, 1, 1, 0);
    vecs[8]  = mkv(1, '0, '1, 8'h20, 8'h20, 0, 8'h00, '0, 0, 1, 0);
    vecs[9]  = mkv(0, b3, '1, '0,    '0,    1, 8'h00, '0, 0, 1, 0);
    vecs[10] = mkv(1, '0, '1, 8'h20, '0,    0, 8'h20, b3, 0, 1, 0);
    vecs[11] = mkv(1, '0, '1, 8'h20, '0,    0, 8'h00, '0, 0, 1, 0);
    vecs[12] = mkv(1, '0, '1, '0,    '0,    0, 8'h00, '0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].empty, vecs[i].data, vecs[i].ready, vecs[i].done, vecs[i].closed);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_valid,
                  vecs[i].exp_cmd, vecs[i].exp_hit, vecs[i].exp_busy, vecs[i].exp_err);
    end

    // Credit limit: six writes to bank 1 with no completions.
    for (int i = 0; i < 6; i++) w[i] = mk(1, 'h20, i, 1);
    idx = 0;
    fires = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      applyStimulus(idx >= 6, (idx < 6) ? w[idx] : '0, '1, '0, '0);
      if (bank_valid[1] && bank_ready[1]) fires++;
      if (fifo_rd_en) idx++;
    end
    compare("credit.fires", 32'(fires), 32'd4);
    compare("credit.valid", 32'(bank_valid), 32'h0);
    compare("credit.held", 32'(bank_cmd), 32'(w[4]));
    compare("credit.rd_en", 32'(fifo_rd_en), 32'h0);
    compare("credit.busy", 32'(busy), 32'h1);
    applyStimulus(0, w[5], '1, 8'h02, '0);
    compare("credit.done_cycle_valid", 32'(bank_valid), 32'h0);
    applyStimulus(0, w[5], '1, '0, '0);
    checkOutput("credit.refire", 1, 8'h02, w[4], 1, 1, 0);
    if (fifo_rd_en) idx++;
    // Drain bank 1 with completions tracked by a small credit model.
    mc = 4;
    for (int cyc = 0; cyc < 20; cyc++) begin
      dv = (mc > 0) ? 1 : 0;
      applyStimulus(idx >= 6, (idx < 6) ? w[idx] : '0, '1, (dv != 0) ? 8'h02 : 8'h00, '0);
      if (!busy && idx >= 6) break;
      fv = (bank_valid[1] && bank_ready[1]) ? 1 : 0;
      if (fifo_rd_en) idx++;
      mc = mc + fv - dv;
    end
    compare("credit.drained_busy", 32'(busy), 32'h0);
    compare("credit.drained_err", 32'(err), 32'h0);

    // Ready stall on bank 3 with a second command waiting in the FIFO.
    c = mk(3, 'h7, 5, 0);
    d = mk(3, 'h8, 6, 1);
    applyStimulus(0, c, 8'hF7, '0, '0);
    checkOutput("stall.pop", 1, 8'h00, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, d, 8'hF7, '0, '0);
      checkOutput($sformatf("stall.c%0d", i), 0, 8'h08, c, 0, 1, 0);
    end
    applyStimulus(0, d, '1, '0, '0);
    checkOutput("stall.release", 1, 8'h08, c, 0, 1, 0);
    applyStimulus(1, '0, '1, '0, '0);
    checkOutput("stall.next", 0, 8'h08, d, 0, 1, 0);
    applyStimulus(1, '0, '1, 8'h08, '0);
    applyStimulus(1, '0, '1, 8'h08, '0);
    applyStimulus(1, '0, '1, '0, '0);
    compare("stall.idle_busy", 32'(busy), 32'h0);

    // Asynchronous reset with three outstanding on bank 4 and one held.
    for (int i = 0; i < 4; i++) g[i] = mk(4, 'h30, i, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, g[i], '1, '0, '0);
    applyStimulus(1, '0, 8'hEF, '0, '0);
    checkOutput("rst.before", 0, 8'h10, g[3], 1, 1, 0);
    fifo_empty = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.during", 0, 8'h00, '0, 0, 0, 0);
    compare("rst.during_cmd", 32'(bank_cmd), 32'h0);
    fifo_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    h = mk(4, 'h30, 7, 0);
    applyStimulus(0, h, '1, '0, '0);
    checkOutput("rst.resume_pop", 1, 8'h00, '0, 0, 0, 0);
    applyStimulus(1, '0, '1, '0, '0);
    checkOutput("rst.resume_issue", 0, 8'h10, h, 0, 1, 0);
    applyStimulus(1, '0, '1, 8'h10, '0);
    checkOutput("rst.resume_done", 0, 8'h00, '0, 0, 1, 0);
    applyStimulus(1, '0, '1, '0, '0);
    checkOutput("rst.resume_idle", 0, 8'h00, '0, 0, 0, 0);

    // Illegal op on bank 0 is dropped, then a legal command issues.
    e = mk(0, 1, 1, 3);
    f = mk(0, 2, 2, 0);
    applyStimulus(0, e, '1, '0, '0);
    checkOutput("illegal.pop", 1, 8'h00, '0, 0, 0, 0);
    applyStimulus(0, f, '1, '0, '0);
    checkOutput("illegal.held", 1, 8'h00, '0, 0, 1, 0);
    applyStimulus(1, '0, '1, '0, '0);
    checkOutput("illegal.next", 0, 8'h01, f, 0, 1, 1);
    applyStimulus(1, '0, '1, 8'h01, '0);
    applyStimulus(1, '0, '1, '0, '0);
    checkOutput("illegal.idle", 0, 8'h00, '0, 0, 0, 1);

    // Completion on bank 6 with nothing outstanding.
    doReset();
    applyStimulus(1, '0, '1, 8'h40, '0);
    checkOutput("underflow.pulse", 0, 8'h00, '0, 0, 0, 0);
    applyStimulus(1, '0, '1, '0, '0);
    checkOutput("underflow.after", 0, 8'h00, '0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
